// File: rtl/obi_reg_bridge.sv
// obi_reg_bridge: OBI slave to valid/ready register-bus bridge.
// Carries one transaction at a time through IDLE -> ACCESS -> RESP, aborts
// slow accesses after TIMEOUT_CYCLES and counts errored or timed-out accesses.
module obi_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        obi_req_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_gnt_o,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        reg_valid_o,
  output logic        reg_write_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  input  logic        reg_ready_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_error_i,
  input  logic        err_clr_i,
  output logic [7:0]  err_count_o,
  output logic        timeout_intr_o
);

  // A zero timeout still needs a legal (unused) one-bit counter.
  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             access_done;
  logic             access_timeout;
  logic             err_event;

  // Per-cycle handshake decode: grant, completion, timeout and error events.
  always_comb begin
    // NOTE: each signal gets a default before any conditional assignment so no
    // path leaves it unassigned, which would otherwise infer a latch.
    obi_gnt_o      = 1'b0;
    access_done    = 1'b0;
    access_timeout = 1'b0;
    if (state == IDLE) begin
      obi_gnt_o = obi_req_i;
    end
    if (state == ACCESS) begin
      access_done    = reg_ready_i;
      // A ready arriving on the limit cycle wins over the timeout.
      access_timeout = TIMEOUT_EN && !reg_ready_i && (tmo_cnt == CNT_LIMIT);
    end
    err_event      = (access_done && reg_error_i) || access_timeout;
    timeout_intr_o = access_timeout;
  end

  // Transaction FSM: holding registers, captured response and timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and the block order cannot create races.
    if (!rst_ni) begin
      state        <= IDLE;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      reg_valid_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_wstrb_o  <= '0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (obi_req_i) begin
            reg_addr_o  <= obi_addr_i;
            reg_write_o <= obi_we_i;
            reg_wstrb_o <= obi_be_i;
            reg_wdata_o <= obi_wdata_i;
            reg_valid_o <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (reg_ready_i) begin
            // Writes always answer with zero data, errored reads with ERR_RDATA.
            if (reg_write_o) begin
              obi_rdata_o <= '0;
            end else if (reg_error_i) begin
              obi_rdata_o <= ERR_RDATA;
            end else begin
              obi_rdata_o <= reg_rdata_i;
            end
            reg_valid_o  <= 1'b0;
            obi_rvalid_o <= 1'b1;
            state        <= RESP;
          end else if (access_timeout) begin
            obi_rdata_o  <= ERR_RDATA;
            reg_valid_o  <= 1'b0;
            obi_rvalid_o <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          obi_rvalid_o <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          obi_rvalid_o <= 1'b0;
          reg_valid_o  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Saturating error counter; a clear overrides a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
    end else if (err_clr_i) begin
      err_count_o <= '0;
    end else if (err_event && (err_count_o != 8'hFF)) begin
      err_count_o <= err_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_obi_reg_bridge.sv
// tb_obi_reg_bridge: table-driven per-cycle vectors for the basic read, write,
// error and ready-at-limit flows, plus hand-written sequences for timeout,
// counter saturation, back-to-back requests and mid-transaction reset.
module tb_obi_reg_bridge;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] ordata;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        clr;
  logic [7:0]  ecnt;
  logic        intr;

  int n_vec  = 0;
  int n_miss = 0;

  obi_reg_bridge #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hBADCAB1E)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .obi_req_i      (req),
    .obi_addr_i     (addr),
    .obi_we_i       (we),
    .obi_be_i       (be),
    .obi_wdata_i    (wdata),
    .obi_gnt_o      (gnt),
    .obi_rvalid_o   (rvalid),
    .obi_rdata_o    (ordata),
    .reg_valid_o    (reg_valid),
    .reg_write_o    (reg_write),
    .reg_addr_o     (reg_addr),
    .reg_wdata_o    (reg_wdata),
    .reg_wstrb_o    (reg_wstrb),
    .reg_ready_i    (reg_ready),
    .reg_rdata_i    (rdata),
    .reg_error_i    (err),
    .err_clr_i      (clr),
    .err_count_o    (ecnt),
    .timeout_intr_o (intr)
  );

  logic reg_ready;
  assign reg_ready = ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        clr;
    logic        gnt;
    logic        valid;
    logic        write;
    logic [31:0] raddr;
    logic [31:0] rwdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] ordata;
    logic        intr;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] i_req, input logic [31:0] i_addr, input logic [31:0] i_we,
    input logic [31:0] i_be, input logic [31:0] i_wdata, input logic [31:0] i_ready,
    input logic [31:0] i_rdata, input logic [31:0] i_err, input logic [31:0] i_clr,
    input logic [31:0] e_gnt, input logic [31:0] e_valid, input logic [31:0] e_write,
    input logic [31:0] e_raddr, input logic [31:0] e_rwdata, input logic [31:0] e_wstrb,
    input logic [31:0] e_rvalid, input logic [31:0] e_ordata, input logic [31:0] e_intr,
    input logic [31:0] e_ecnt);
    vec_t v;
    v.req    = i_req[0];
    v.addr   = i_addr;
    v.we     = i_we[0];
    v.be     = i_be[3:0];
    v.wdata  = i_wdata;
    v.ready  = i_ready[0];
    v.rdata  = i_rdata;
    v.err    = i_err[0];
    v.clr    = i_clr[0];
    v.gnt    = e_gnt[0];
    v.valid  = e_valid[0];
    v.write  = e_write[0];
    v.raddr  = e_raddr;
    v.rwdata = e_rwdata;
    v.wstrb  = e_wstrb[3:0];
    v.rvalid = e_rvalid[0];
    v.ordata = e_ordata;
    v.intr   = e_intr[0];
    v.ecnt   = e_ecnt[7:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    ready = 1'b0; rdata = '0; err = 1'b0; clr = 1'b0;
  endtask

  // One read/write from IDLE with the slave answering in the first ACCESS cycle.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] rd,
                     input logic e, input logic c,
                     output logic [31:0] data, output logic rv, output int waits);
    next_cycle();
    req = 1'b1; addr = a; we = w; be = 4'hF; wdata = 32'h13572468;
    ready = 1'b0; err = 1'b0; clr = 1'b0; rdata = '0;
    #1;
    waits = 0;
    while (!gnt && waits < 8) begin
      next_cycle();
      #1;
      waits++;
    end
    check("txn_gnt", gnt, 1);
    next_cycle();
    req = 1'b0; ready = 1'b1; rdata = rd; err = e; clr = c;
    #1;
    check("txn_access_valid", reg_valid, 1);
    next_cycle();
    ready = 1'b0; err = 1'b0; clr = 1'b0; rdata = '0;
    #1;
    data = ordata;
    rv   = rvalid;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        rv;
    int          w;

    // req addr we be wdata ready rdata err clr | gnt valid write raddr rwdata wstrb rvalid ordata intr ecnt
    // Read at 0x10 answered in the first ACCESS cycle.
    vecs.push_back(mk(1,'h10,0,'hF,0,          0,0,0,0,           1,0,0,0,0,0,                   0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,               1,'h12345678,0,0,  0,1,0,'h10,0,'hF,              0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,0,0,0,0,0,                   1,'h12345678,0,0));
    // Write, ready after three wait cycles; request during RESP is not granted.
    vecs.push_back(mk(1,'h20,1,'h3,'hA5A5A5A5, 0,0,0,0,           1,0,0,0,0,0,                   0,'h12345678,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,1,'h20,'hA5A5A5A5,'h3,     0,'h12345678,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,1,'h20,'hA5A5A5A5,'h3,     0,'h12345678,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,1,'h20,'hA5A5A5A5,'h3,     0,'h12345678,0,0));
    vecs.push_back(mk(0,0,0,0,0,               1,'hDEADBEEF,0,0,  0,1,1,'h20,'hA5A5A5A5,'h3,     0,'h12345678,0,0));
    vecs.push_back(mk(1,'h30,0,'hF,0,          0,0,0,0,           0,0,0,0,0,0,                   1,0,0,0));
    // Read with slave error.
    vecs.push_back(mk(1,'h30,0,'hF,0,          0,0,0,0,           1,0,0,0,0,0,                   0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,               1,'h11111111,1,0,  0,1,0,'h30,0,'hF,              0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,0,0,0,0,0,                   1,'hBADCAB1E,0,1));
    // Write with slave error answers zero data.
    vecs.push_back(mk(1,'h40,1,'hC,'h0F0F0F0F, 0,0,0,0,           1,0,0,0,0,0,                   0,'hBADCAB1E,0,1));
    vecs.push_back(mk(0,0,0,0,0,               1,'h22222222,1,0,  0,1,1,'h40,'h0F0F0F0F,'hC,     0,'hBADCAB1E,0,1));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,0,0,0,0,0,                   1,0,0,2));
    // Ready arrives exactly on the timeout-limit cycle: normal completion.
    vecs.push_back(mk(1,'h50,0,'hF,0,          0,0,0,0,           1,0,0,0,0,0,                   0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,0,'h50,0,'hF,              0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,0,'h50,0,'hF,              0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,0,'h50,0,'hF,              0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,1,0,'h50,0,'hF,              0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               1,'hCAFEF00D,0,0,  0,1,0,'h50,0,'hF,              0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,0,0,0,0,0,                   1,'hCAFEF00D,0,2));
    // Clear, with stray slave responses in IDLE that must be ignored.
    vecs.push_back(mk(0,0,0,0,0,               1,'h33333333,1,1,  0,0,0,0,0,0,                   0,'hCAFEF00D,0,2));
    vecs.push_back(mk(0,0,0,0,0,               1,'h33333333,1,0,  0,0,0,0,0,0,                   0,'hCAFEF00D,0,0));
    vecs.push_back(mk(0,0,0,0,0,               0,0,0,0,           0,0,0,0,0,0,                   0,'hCAFEF00D,0,0));

    // Reset state.
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", ordata, 0);
    check("rst_valid", reg_valid, 0);
    check("rst_write", reg_write, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_wstrb", reg_wstrb, 0);
    check("rst_ecnt", ecnt, 0);
    check("rst_intr", intr, 0);
    rst_n = 1'b1;

    // Table-driven per-cycle vectors.
    foreach (vecs[i]) begin
      next_cycle();
      req = vecs[i].req; addr = vecs[i].addr; we = vecs[i].we; be = vecs[i].be;
      wdata = vecs[i].wdata; ready = vecs[i].ready; rdata = vecs[i].rdata;
      err = vecs[i].err; clr = vecs[i].clr;
      #1;
      check($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("v%0d_valid", i), reg_valid, vecs[i].valid);
      check($sformatf("v%0d_rvalid", i), rvalid, vecs[i].rvalid);
      check($sformatf("v%0d_rdata", i), ordata, vecs[i].ordata);
      check($sformatf("v%0d_intr", i), intr, vecs[i].intr);
      check($sformatf("v%0d_ecnt", i), ecnt, vecs[i].ecnt);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_write", i), reg_write, vecs[i].write);
        check($sformatf("v%0d_addr", i), reg_addr, vecs[i].raddr);
        check($sformatf("v%0d_wdata", i), reg_wdata, vecs[i].rwdata);
        check($sformatf("v%0d_wstrb", i), reg_wstrb, vecs[i].wstrb);
      end
    end

    // Timeout: limit 4, read never answered, late ready 2 cycles after the abort.
    begin
      int intr_cnt = 0;
      int intr_at  = -1;
      int rv_cnt   = 0;
      int rv_at    = -1;
      logic [31:0] rv_data = '0;
      next_cycle();
      idle_inputs();
      req = 1'b1; addr = 32'h60; be = 4'hF;
      #1;
      check("tmo_gnt", gnt, 1);
      for (int c = 0; c < 12; c++) begin
        next_cycle();
        idle_inputs();
        if (intr_at >= 0 && c == intr_at + 2) begin
          ready = 1'b1; rdata = 32'h77777777; err = 1'b1;
        end
        #1;
        if (intr) begin
          intr_cnt++;
          if (intr_at < 0) intr_at = c;
        end
        if (rvalid) begin
          rv_cnt++;
          if (rv_at < 0) begin
            rv_at   = c;
            rv_data = ordata;
          end
        end
      end
      check("tmo_intr_pulses", intr_cnt, 1);
      check("tmo_intr_cycle", intr_at, 4);
      check("tmo_rvalid_cycle", rv_at, 5);
      check("tmo_rvalid_count", rv_cnt, 1);
      check("tmo_rdata", rv_data, 32'hBADCAB1E);
      check("tmo_ecnt", ecnt, 1);
      check("tmo_rdata_held", ordata, 32'hBADCAB1E);
    end

    // Error counter saturation, then clear racing an error.
    for (int k = 0; k < 254; k++) begin
      txn(32'h300, 1'b0, 32'h0, 1'b1, 1'b0, d, rv, w);
      check("sat_rvalid", rv, 1);
      check("sat_rdata", d, 32'hBADCAB1E);
    end
    check("sat_ecnt_255", ecnt, 255);
    for (int k = 0; k < 6; k++) begin
      txn(32'h304, 1'b0, 32'h0, 1'b1, 1'b0, d, rv, w);
    end
    check("sat_ecnt_hold", ecnt, 255);
    txn(32'h308, 1'b0, 32'h0, 1'b1, 1'b1, d, rv, w);
    check("clr_vs_err_ecnt", ecnt, 0);
    check("clr_vs_err_rdata", d, 32'hBADCAB1E);
    txn(32'h30C, 1'b0, 32'h0, 1'b1, 1'b0, d, rv, w);
    check("after_clr_ecnt", ecnt, 1);

    // Back-to-back: request held high for three transactions.
    begin
      int grants = 0;
      int resps  = 0;
      int last_g = -10;
      for (int c = 0; c < 16; c++) begin
        next_cycle();
        idle_inputs();
        req   = (grants < 3);
        addr  = 32'h100 + 32'(grants) * 4;
        be    = 4'hF;
        ready = 1'b1;
        rdata = 32'hD0000000 + 32'(grants) - 32'd1;
        #1;
        check("b2b_gnt_exclusive", gnt & (reg_valid | rvalid), 0);
        if (gnt) begin
          if (grants > 0) check("b2b_spacing", 32'((c - last_g) >= 3), 1);
          last_g = c;
          grants++;
        end
        if (reg_valid) check("b2b_addr", reg_addr, 32'h100 + 32'(grants - 1) * 4);
        if (rvalid) begin
          check("b2b_rdata", ordata, 32'hD0000000 + 32'(resps));
          resps++;
        end
      end
      check("b2b_grants", grants, 3);
      check("b2b_resps", resps, 3);
    end

    // Reset during ACCESS abandons the write; a new read then runs normally.
    next_cycle();
    idle_inputs();
    req = 1'b1; addr = 32'h200; we = 1'b1; be = 4'h6; wdata = 32'h13572468;
    #1;
    check("mid_rst_gnt", gnt, 1);
    next_cycle();
    idle_inputs();
    #1;
    check("mid_rst_valid_before", reg_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", reg_valid, 0);
    check("mid_rst_write", reg_write, 0);
    check("mid_rst_addr", reg_addr, 0);
    check("mid_rst_wdata", reg_wdata, 0);
    check("mid_rst_wstrb", reg_wstrb, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rdata", ordata, 0);
    check("mid_rst_ecnt", ecnt, 0);
    check("mid_rst_intr", intr, 0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      check("in_rst_rvalid", rvalid, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      idle_inputs();
      ready = 1'b1; rdata = 32'h44444444; err = 1'b1;
      #1;
      check("post_rst_rvalid", rvalid, 0);
      check("post_rst_valid", reg_valid, 0);
      check("post_rst_ecnt", ecnt, 0);
    end
    txn(32'h204, 1'b0, 32'h89ABCDEF, 1'b0, 1'b0, d, rv, w);
    check("post_rst_gnt_wait", w, 0);
    check("post_rst_read_rvalid", rv, 1);
    check("post_rst_read_rdata", d, 32'h89ABCDEF);
    next_cycle();
    idle_inputs();
    #1;
    check("post_rst_rvalid_single", rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
